mem_sram_ctrl: RTL and testbench

Memory-stage controller that turns a 32-bit load/store issued by the execute stage into a sequence of 16-bit external SRAM accesses. It sits directly downstream of the ALU: the ALU's LDR/STR result (base + offset) arrives here as the byte address. `ready` is low while an access is in flight so the pipeline can freeze. Each word takes two fixed-latency half-word phases, low half first.

---
 rtl/mem_sram_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: splits a 32-bit load/store into two 16-bit SRAM
// half-word phases (low half first), freezing the pipeline via ready.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lat_wr_q, lat_wr_d;
    logic [WORD_W-1:0] lat_word_q, lat_word_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic [15:0]       shadow_q;
    logic [17:0]       sram_addr_d;
    logic [15:0]       sram_dq_out_d;
    logic              sram_dq_oe_d;
    logic              sram_we_n_d;
    logic              req_c;
    logic [WORD_W-1:0] word_in_c;
    logic              last_c;

    assign req_c     = wr_en | rd_en;
    // Word index is bits [18:2] of the offset from BASE_ADDR (mod 2^32).
    assign word_in_c = WORD_W'((address - 32'(BASE_ADDR)) >> 2);
    assign last_c    = (cnt_q == CNT_LAST);

    // Next-state, request latch and next SRAM pin values (aligned to state_d).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_wr_d      = lat_wr_q;
        lat_word_d    = lat_word_q;
        lat_wdata_d   = lat_wdata_q;
        sram_addr_d   = '0;
        sram_dq_out_d = '0;
        sram_dq_oe_d  = 1'b0;
        sram_we_n_d   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    state_d     = S_LO;
                    cnt_d       = '0;
                    lat_wr_d    = wr_en;
                    lat_word_d  = word_in_c;
                    lat_wdata_d = write_data;
                end
            end
            S_LO: begin
                if (last_c) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_LO) || (state_d == S_HI)) begin
            sram_addr_d = {lat_word_d, (state_d == S_HI)};
            if (lat_wr_d) begin
                sram_we_n_d   = 1'b0;
                sram_dq_oe_d  = 1'b1;
                sram_dq_out_d = (state_d == S_HI) ? lat_wdata_d[31:16] : lat_wdata_d[15:0];
            end
        end
    end

    // State, latched request and registered SRAM pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lat_wr_q    <= 1'b0;
            lat_word_q  <= '0;
            lat_wdata_q <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_wr_q    <= lat_wr_d;
            lat_word_q  <= lat_word_d;
            lat_wdata_q <= lat_wdata_d;
            sram_addr   <= sram_addr_d;
            sram_dq_out <= sram_dq_out_d;
            sram_dq_oe  <= sram_dq_oe_d;
            sram_we_n   <= sram_we_n_d;
        end
    end

    // Load capture: low half into shadow, full word published on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q  <= '0;
            read_data <= '0;
        end else if (!lat_wr_q && last_c) begin
            if (state_q == S_LO) begin
                shadow_q <= sram_dq_in;
            end else if (state_q == S_HI) begin
                read_data <= {sram_dq_in, shadow_q};
            end
        end
    end

    // Pipeline freeze: idle passes through only when no request is pending.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_IDLE:  ready = ~req_c;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: vector table over a behavioural SRAM, read_data
// scoreboard checked at each DONE, plus reset, back-to-back and W=1 sequences.
module tb_mem_sram_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        wr_en1, rd_en1;
    logic [31:0] address1, write_data1, read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1;

    logic        bk_we;
    logic [17:0] bk_addr;
    logic [15:0] bk_data;
    logic [15:0] mem [0:262143];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
        .address(address1), .write_data(write_data1), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
        .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
    );

    // Behavioural SRAM with a backdoor write port for the bench.
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
        else if (bk_we) mem[bk_addr] <= bk_data;
    end

    // Second instance reads an address-derived pattern.
    assign sram_dq_in1 = sram_addr1[15:0] ^ 16'hA5A5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: at every DONE of the main instance, read_data must match the queue head.
    always @(negedge clk) begin
        if (rst && (wr_en | rd_en) && ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got DONE with no expected entry (t=%0t)", $time);
            end else begin
                chk("sb_rdata", read_data, sb_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_sa;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_access(input vec_t v);
        logic        wr_eff;
        logic [15:0] exp_dq;
        wr_eff = v.wr;
        @(posedge clk); #1;
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        sb_q.push_back(v.exp_rdata);
        @(negedge clk);
        chk("ready_c0", 32'(ready), 32'd0);
        for (int c = 1; c <= 2 * W; c++) begin
            @(negedge clk);
            exp_dq = !wr_eff ? 16'h0 : (c > W) ? v.wdata[31:16] : v.wdata[15:0];
            chk("ready_busy", 32'(ready), 32'd0);
            chk("sram_addr", 32'(sram_addr), 32'(v.exp_sa | 18'(c > W)));
            chk("we_n", 32'(sram_we_n), 32'(!wr_eff));
            chk("dq_oe", 32'(sram_dq_oe), 32'(wr_eff));
            chk("dq_out", 32'(sram_dq_out), 32'(exp_dq));
        end
        @(negedge clk);
        chk("ready_done", 32'(ready), 32'd1);
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("addr_done", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = '0; write_data1 = '0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;

        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1027, 32'h0, 18'd0, 32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'd0, 32'hCAFEF00D, 18'h3FE00, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd0, 32'h0, 18'h3FE00, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq", 32'(sram_dq_out), 32'd0);
        #1 rst = 1'b1;

        for (int i = 0; i < 7; i++) run_access(vecs[i]);

        // Reset in cycle 3 of a load aborts it and clears read_data.
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1028;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("mid_ready_c3", 32'(ready), 32'd0);
        chk("mid_rdata_c3", read_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rdata", read_data, 32'h0);
        chk("mid_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_ready", 32'(ready), 32'd1);
        chk("mid_addr", 32'(sram_addr), 32'd0);
        #1 rst = 1'b1;

        // Back-to-back loads held high; memory changed between accesses by backdoor.
        sb_q.push_back(32'hDEADBEEF);
        sb_q.push_back(32'h0BADF00D);
        sb_q.push_back(32'h0BADF00D);
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1028;
        for (int c = 0; c < 3 * (2 * W + 2); c++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready), 32'((c % (2 * W + 2)) == (2 * W + 1)));
            chk("b2b_rdata", read_data,
                (c < 2 * W + 1) ? 32'h0 : (c < 4 * W + 3) ? 32'hDEADBEEF : 32'h0BADF00D);
            if (c == 6) begin bk_we = 1'b1; bk_addr = 18'd2; bk_data = 16'hF00D; end
            if (c == 7) begin bk_addr = 18'd3; bk_data = 16'h0BAD; end
            if (c == 8) bk_we = 1'b0;
        end
        @(posedge clk); #1;
        rd_en = 1'b0;

        // W=1: one-cycle phases, address change during LO must be ignored.
        @(posedge clk); #1;
        rd_en1 = 1'b1; address1 = 32'd1032;
        @(negedge clk);
        chk("w1_ready_c0", 32'(ready1), 32'd0);
        @(posedge clk); #1;
        address1 = 32'd1424;
        @(negedge clk);
        chk("w1_addr_lo", 32'(sram_addr1), 32'd4);
        chk("w1_ready_c1", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_addr_hi", 32'(sram_addr1), 32'd5);
        chk("w1_ready_c2", 32'(ready1), 32'd0);
        @(negedge clk);
        chk("w1_ready_c3", 32'(ready1), 32'd1);
        chk("w1_rdata", read_data1, {16'd5 ^ 16'hA5A5, 16'd4 ^ 16'hA5A5});
        @(posedge clk); #1;
        rd_en1 = 1'b0;

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
